ad_ip_jesd204_tpl_adc_channel_mon: RTL and testbench
====================================================

Name: ad_ip_jesd204_tpl_adc_channel_mon

Overview:
- Per-channel ADC transport-layer back end: formats each sample of a multi-sample beat and checks the raw stream against a selected test pattern.
- Pattern check covers PN9, PN23 and ramp.
- Checker has a lock state machine with hysteresis and a saturating error counter.
- Instantiated once per converter channel between the JESD204 TPL deframer and the DMA/pack stage; register-map bits drive the config inputs.

Parameters:
CONVERTER_RESOLUTION, 14, raw bits per sample (R); legal 8..16
DATA_PATH_WIDTH, 2, samples per beat (N); legal 1..8
BITS_PER_SAMPLE, 16, formatted sample width (B); B >= R
OOS_THRESHOLD, 4, consecutive good/bad valid beats to enter/leave lock; legal >= 1
ERR_CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
raw_valid  in  1  raw beat qualifier
raw_data  in  R*N  raw samples; sample 0 in LSBs and first in time
fmt_valid  out  1  formatted beat qualifier
fmt_data  out  B*N  formatted samples, same ordering as raw_data
dfmt_enable  in  1  formatter enable
dfmt_type  in  1  1 = invert sample MSB (offset binary to two's complement)
dfmt_sign_extend  in  1  1 = fill upper B-R bits with the resulting MSB
pn_seq_sel  in  4  0 = off, 1 = PN9, 2 = PN23, 3 = ramp, others = off
err_cnt_clr  in  1  synchronous clear of err_cnt
pn_oos  out  1  1 = checker not locked
pn_err  out  1  one-cycle pulse per mismatching beat while locked
err_cnt  out  ERR_CNT_WIDTH  saturating count of mismatching beats while locked

Behaviour:
- Reset values: fmt_valid=0, fmt_data=0, pn_oos=1, pn_err=0, err_cnt=0. Internal: state=OOS, good/bad counters=0, history=0, seed count=0.
- Formatter (1-cycle registered latency):
  - fmt_valid is raw_valid delayed one cycle.
  - fmt_data updates only on valid beats and holds otherwise.
  - Per sample s: m = s[R-1] ^ (dfmt_enable & dfmt_type).
  - Low R bits = {m, s[R-2:0]}.
  - Upper B-R bits = m if (dfmt_enable & dfmt_sign_extend), else 0.
- Checker operates on raw_data and advances only on raw_valid=1 beats; invalid beats change nothing.
- Ramp: expected sample k = previous sample + 1 mod 2^R. "Previous" for sample 0 is the last sample of the prior valid beat.
- PN9 / PN23 are self-synchronising:
  - Bit stream is samples in order, each sample MSB-first.
  - PN9: expected b[i] = b[i-9] ^ b[i-5].
  - PN23: expected b[i] = b[i-23] ^ b[i-18].
  - The bits b[i-x] are received bits, held in a 23-bit history register spanning beats.
- Seeding:
  - After reset or any change of pn_seq_sel, the first S valid beats only load history and are not compared.
  - S = 1 for ramp; S = ceil(9/(R*N)) for PN9; S = ceil(23/(R*N)) for PN23.
- A beat is good iff every compared sample and bit matches.
- State machine:
  - OOS: a good beat increments good_cnt and a bad beat clears it. When good_cnt reaches OOS_THRESHOLD, go to SYNC and clear both counters. pn_oos=0 from the next cycle.
  - SYNC, bad beat: pn_err=1 for that one cycle (registered, one cycle after the beat), err_cnt increments (saturating at all-ones), bad_cnt increments.
  - SYNC, good beat: bad_cnt clears.
  - SYNC exit: when bad_cnt reaches OOS_THRESHOLD, go to OOS with pn_oos=1. The triggering beat is still counted in err_cnt.
- pn_seq_sel off or reserved: state forced to OOS, pn_oos=1, pn_err=0, err_cnt holds.
- pn_seq_sel change: immediate return to OOS, counters cleared, reseed. err_cnt is not cleared.
- err_cnt_clr:
  - Sets err_cnt=0 next cycle.
  - Clear wins over a simultaneous error; that error is dropped and pn_err still pulses.
  - Does not affect lock state.
- Reset mid-operation: asynchronous return to reset values; lock is rebuilt from seeding.

Test Plan:
1. Formatter (R=14, B=16), enable=1, type=1, se=1: raw 0x2000 -> 0x0000; raw 0x1FFF -> 0xFFFF. With enable=0: raw 0x2000 -> 0x2000. fmt_valid and fmt_data appear exactly one cycle after raw_valid.
2. Ramp lock (N=2, OOS_THRESHOLD=4): sel=3, beats (0,1),(2,3),...,(8,9) -> seed on beat 1, pn_oos falls the cycle after beat 5, err_cnt=0. Inserting raw_valid=0 gaps between beats gives identical lock timing in valid-beat terms.
3. Error injection: locked ramp, one beat (10,99) -> single pn_err pulse, err_cnt=1, pn_oos stays 0. Resume with (100,101) -> no further errors.
4. Loss of lock: 4 consecutive corrupted beats while locked -> err_cnt=4, pn_oos=1 after the 4th. Then 4 good beats -> re-lock.
5. PN9 and PN23 streams from a reference LFSR with arbitrary start state -> lock after S+4 valid beats. A single flipped bit while locked -> exactly one pn_err. Switching sel 1->2 mid-lock -> pn_oos=1 the next cycle.
6. ERR_CNT_WIDTH=4, 20 bad beats while locked (re-locking as needed) -> err_cnt saturates at 15. err_cnt_clr -> 0. err_cnt_clr coincident with a bad beat -> err_cnt=0. rst asserted mid-lock -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_channel_mon.sv
// Per-channel ADC transport-layer back end: registered sample formatter plus a
// PN9/PN23/ramp checker with lock hysteresis and a saturating error counter.
module ad_ip_jesd204_tpl_adc_channel_mon #(
    parameter int CONVERTER_RESOLUTION = 14,
    parameter int DATA_PATH_WIDTH      = 2,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int OOS_THRESHOLD        = 4,
    parameter int ERR_CNT_WIDTH        = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              raw_valid,
    input  logic [CONVERTER_RESOLUTION*DATA_PATH_WIDTH-1:0]   raw_data,
    output logic                                              fmt_valid,
    output logic [BITS_PER_SAMPLE*DATA_PATH_WIDTH-1:0]        fmt_data,
    input  logic                                              dfmt_enable,
    input  logic                                              dfmt_type,
    input  logic                                              dfmt_sign_extend,
    input  logic [3:0]                                        pn_seq_sel,
    input  logic                                              err_cnt_clr,
    output logic                                              pn_oos,
    output logic                                              pn_err,
    output logic [ERR_CNT_WIDTH-1:0]                          err_cnt
);

    localparam int R     = CONVERTER_RESOLUTION;
    localparam int N     = DATA_PATH_WIDTH;
    localparam int B     = BITS_PER_SAMPLE;
    localparam int RN    = R * N;
    localparam int CNT_W = $clog2(OOS_THRESHOLD + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OOS_THRESHOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] SEL_PN9  = 4'd1;
    localparam logic [3:0] SEL_PN23 = 4'd2;
    localparam logic [3:0] SEL_RAMP = 4'd3;

    // Beats needed to fill the history before the first comparison.
    localparam logic [1:0] SEED_RAMP = 2'd1;
    localparam logic [1:0] SEED_PN9  = 2'((9 + RN - 1) / RN);
    localparam logic [1:0] SEED_PN23 = 2'((23 + RN - 1) / RN);

    localparam logic [0:0] ST_OOS  = 1'b0;
    localparam logic [0:0] ST_SYNC = 1'b1;

    function automatic logic [B-1:0] fmt_sample(input logic [R-1:0] s,
                                                input logic inv,
                                                input logic sext);
        logic [B-1:0] f;
        logic         m;
        m          = s[R-1] ^ inv;
        f          = {B{m & sext}};
        f[R-1:0]   = {m, s[R-2:0]};
        return f;
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_CNT_WIDTH'(1);
    endfunction

    logic                   fmt_valid_q;
    logic [B*N-1:0]         fmt_data_q, fmt_data_d;
    logic [22:0]            hist_q, hist_d;
    logic [R-1:0]           last_q, last_d;
    logic [R-1:0]           smp;
    logic                   ramp_bad, pn_bad, beat_bad;
    logic [3:0]             sel_q;
    logic                   sel_on;
    logic [1:0]             seed_need;
    logic [1:0]             seed_cnt_q, seed_cnt_d;
    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]       bad_cnt_q, bad_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                   pn_err_q, pn_err_d;

    // Formatter stage: one register between raw and formatted beats.
    always_comb begin
        fmt_data_d = fmt_data_q;
        if (raw_valid) begin
            for (int s = 0; s < N; s++) begin
                fmt_data_d[s*B +: B] = fmt_sample(raw_data[s*R +: R],
                                                  dfmt_enable & dfmt_type,
                                                  dfmt_enable & dfmt_sign_extend);
            end
        end
    end

    // Pattern comparison: walk the beat in time order, sample by sample and
    // MSB first, always feeding the received bits (not the expected ones) back
    // into the history so the checker resynchronises on its own.
    always_comb begin
        hist_d   = hist_q;
        last_d   = last_q;
        smp      = '0;
        ramp_bad = 1'b0;
        pn_bad   = 1'b0;
        if (raw_valid) begin
            for (int s = 0; s < N; s++) begin
                smp = raw_data[s*R +: R];
                if (smp != R'(last_d + R'(1)))
                    ramp_bad = 1'b1;
                last_d = smp;
                for (int b = R - 1; b >= 0; b--) begin
                    if (pn_seq_sel == SEL_PN23) begin
                        if (smp[b] != (hist_d[22] ^ hist_d[17]))
                            pn_bad = 1'b1;
                    end else begin
                        if (smp[b] != (hist_d[8] ^ hist_d[4]))
                            pn_bad = 1'b1;
                    end
                    hist_d = {hist_d[21:0], smp[b]};
                end
            end
        end
        beat_bad = (pn_seq_sel == SEL_RAMP) ? ramp_bad : pn_bad;
    end

    always_comb begin
        sel_on    = 1'b1;
        seed_need = SEED_RAMP;
        case (pn_seq_sel)
            SEL_PN9:  seed_need = SEED_PN9;
            SEL_PN23: seed_need = SEED_PN23;
            SEL_RAMP: seed_need = SEED_RAMP;
            default:  sel_on    = 1'b0;
        endcase
    end

    // Lock state machine with separate good/bad run counters for hysteresis.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        seed_cnt_d = seed_cnt_q;
        err_cnt_d  = err_cnt_q;
        pn_err_d   = 1'b0;
        if (!sel_on) begin
            state_d    = ST_OOS;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            seed_cnt_d = '0;
        end else if (pn_seq_sel != sel_q) begin
            // A beat arriving with the new selection is the first seed beat.
            state_d    = ST_OOS;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            seed_cnt_d = raw_valid ? 2'd1 : 2'd0;
        end else if (raw_valid) begin
            if (seed_cnt_q < seed_need) begin
                seed_cnt_d = seed_cnt_q + 2'd1;
            end else if (state_q == ST_OOS) begin
                if (beat_bad) begin
                    good_cnt_d = '0;
                end else if (good_cnt_q == CNT_LAST) begin
                    state_d    = ST_SYNC;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end else begin
                    good_cnt_d = good_cnt_q + CNT_ONE;
                end
            end else begin
                if (!beat_bad) begin
                    bad_cnt_d = '0;
                end else begin
                    pn_err_d  = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    if (bad_cnt_q == CNT_LAST) begin
                        state_d    = ST_OOS;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + CNT_ONE;
                    end
                end
            end
        end
        if (err_cnt_clr)
            err_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmt_valid_q <= 1'b0;
            fmt_data_q  <= '0;
            hist_q      <= '0;
            last_q      <= '0;
            sel_q       <= '0;
            seed_cnt_q  <= '0;
            state_q     <= ST_OOS;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            err_cnt_q   <= '0;
            pn_err_q    <= 1'b0;
        end else begin
            fmt_valid_q <= raw_valid;
            fmt_data_q  <= fmt_data_d;
            hist_q      <= hist_d;
            last_q      <= last_d;
            sel_q       <= pn_seq_sel;
            seed_cnt_q  <= seed_cnt_d;
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_cnt_q   <= err_cnt_d;
            pn_err_q    <= pn_err_d;
        end
    end

    assign fmt_valid = fmt_valid_q;
    assign fmt_data  = fmt_data_q;
    assign pn_oos    = (state_q == ST_OOS);
    assign pn_err    = pn_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_channel_mon.sv
// Directed bench for the channel monitor: a behavioural model checked every
// cycle plus hand-computed literal expectations at key points.
module tb_ad_ip_jesd204_tpl_adc_channel_mon;

    localparam int R     = 14;
    localparam int N     = 2;
    localparam int B     = 16;
    localparam int TH    = 4;
    localparam int ECW   = 4;
    localparam int ECMAX = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           raw_valid = 1'b0;
    logic [R*N-1:0] raw_data = '0;
    logic           fmt_valid;
    logic [B*N-1:0] fmt_data;
    logic           dfmt_enable = 1'b0;
    logic           dfmt_type = 1'b0;
    logic           dfmt_sign_extend = 1'b0;
    logic [3:0]     pn_seq_sel = 4'd0;
    logic           err_cnt_clr = 1'b0;
    logic           pn_oos;
    logic           pn_err;
    logic [ECW-1:0] err_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    int rv = 0;
    logic [22:0] g9  = 23'h0001A5;
    logic [22:0] g23 = 23'h3A5C71;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_channel_mon #(
        .CONVERTER_RESOLUTION(R),
        .DATA_PATH_WIDTH(N),
        .BITS_PER_SAMPLE(B),
        .OOS_THRESHOLD(TH),
        .ERR_CNT_WIDTH(ECW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_valid(raw_valid),
        .raw_data(raw_data),
        .fmt_valid(fmt_valid),
        .fmt_data(fmt_data),
        .dfmt_enable(dfmt_enable),
        .dfmt_type(dfmt_type),
        .dfmt_sign_extend(dfmt_sign_extend),
        .pn_seq_sel(pn_seq_sel),
        .err_cnt_clr(err_cnt_clr),
        .pn_oos(pn_oos),
        .pn_err(pn_err),
        .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic           m_fv = 1'b0;
    logic [B*N-1:0] m_fd = '0;
    bit             m_err = 1'b0;
    int             m_cnt = 0;
    bit             m_locked = 1'b0;
    int             m_run = 0;
    int             m_seeded = 0;
    int             m_prev_sel = 0;
    int             m_last = 0;
    bit             m_hist[$];

    function automatic logic [B*N-1:0] fmt_model(input logic [R*N-1:0] raw, input logic en,
                                                 input logic typ, input logic se);
        logic [B*N-1:0] res;
        int v;
        res = '0;
        for (int s = 0; s < N; s++) begin
            v = int'(raw[s*R +: R]);
            if (en && typ) v = v ^ (1 << (R - 1));
            if (en && se && v >= (1 << (R - 1))) v = v + ((1 << B) - (1 << R));
            res[s*B +: B] = B'(v);
        end
        return res;
    endfunction

    task automatic model_reset();
        m_fv = 1'b0; m_fd = '0; m_err = 1'b0; m_cnt = 0; m_locked = 1'b0;
        m_run = 0; m_seeded = 0; m_prev_sel = 0; m_last = 0;
        m_hist.delete();
        for (int i = 0; i < 23; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_step();
        int sel, need, smp, n;
        bit on, ok, x;
        logic [R-1:0] sv;
        sel  = int'(pn_seq_sel);
        on   = (sel >= 1 && sel <= 3);
        need = (sel == 3) ? 1 : (sel == 1) ? (9 + R*N - 1) / (R*N) : (23 + R*N - 1) / (R*N);
        ok   = 1'b1;
        m_fv = raw_valid;
        if (raw_valid) begin
            m_fd = fmt_model(raw_data, dfmt_enable, dfmt_type, dfmt_sign_extend);
            for (int s = 0; s < N; s++) begin
                sv  = raw_data[s*R +: R];
                smp = int'(sv);
                if (sel == 3 && smp != (m_last + 1) % (1 << R)) ok = 1'b0;
                m_last = smp;
                for (int b = R - 1; b >= 0; b--) begin
                    x = sv[b];
                    n = m_hist.size();
                    if (sel == 1 && x != (m_hist[n-9] ^ m_hist[n-5])) ok = 1'b0;
                    if (sel == 2 && x != (m_hist[n-23] ^ m_hist[n-18])) ok = 1'b0;
                    m_hist.push_back(x);
                    if (m_hist.size() > 32) void'(m_hist.pop_front());
                end
            end
        end
        m_err = 1'b0;
        if (!on) begin
            m_locked = 1'b0; m_run = 0; m_seeded = 0;
        end else if (sel != m_prev_sel) begin
            m_locked = 1'b0; m_run = 0; m_seeded = raw_valid ? 1 : 0;
        end else if (raw_valid) begin
            if (m_seeded < need) begin
                m_seeded++;
            end else if (!m_locked) begin
                m_run = ok ? m_run + 1 : 0;
                if (m_run == TH) begin m_locked = 1'b1; m_run = 0; end
            end else begin
                if (!ok) begin
                    m_err = 1'b1;
                    if (m_cnt < ECMAX) m_cnt++;
                    m_run++;
                end else begin
                    m_run = 0;
                end
                if (m_run == TH) begin m_locked = 1'b0; m_run = 0; end
            end
        end
        if (err_cnt_clr) m_cnt = 0;
        m_prev_sel = sel;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("fmt_valid", fmt_valid, m_fv);
                chk("fmt_data", fmt_data, m_fd);
                chk("pn_oos", pn_oos, !m_locked);
                chk("pn_err", pn_err, m_err);
                chk("err_cnt", err_cnt, m_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [R-1:0] s0, input logic [R-1:0] s1);
        raw_valid = v;
        raw_data  = {s1, s0};
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_beat();
        drive(1'b1, R'(rv), R'(rv + 1));
        rv += 2;
    endtask

    task automatic bad_beat();
        drive(1'b1, R'(rv + 2), R'(rv + 3));
        rv += 4;
    endtask

    task automatic pn_beat(input bit use23, input bit flip);
        logic [R*N-1:0] d;
        logic nb;
        d = '0;
        for (int s = 0; s < N; s++) begin
            for (int b = R - 1; b >= 0; b--) begin
                if (use23) begin
                    nb  = g23[22] ^ g23[17];
                    g23 = {g23[21:0], nb};
                end else begin
                    nb = g9[8] ^ g9[4];
                    g9 = {g9[21:0], nb};
                end
                d[s*R + b] = nb;
            end
        end
        if (flip) d[R-1] = ~d[R-1];
        drive(1'b1, d[R-1:0], d[2*R-1:R]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        @(posedge clk);
        #1;
        chk("rst_fmt_valid", fmt_valid, 1'b0);
        chk("rst_fmt_data", fmt_data, 32'h0);
        chk("rst_pn_oos", pn_oos, 1'b1);
        chk("rst_pn_err", pn_err, 1'b0);
        chk("rst_err_cnt", err_cnt, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        // Formatter
        dfmt_enable = 1'b1; dfmt_type = 1'b1; dfmt_sign_extend = 1'b1;
        raw_valid = 1'b1;
        raw_data  = {14'h1FFF, 14'h2000};
        #2;
        chk("fmt_valid_before_edge", fmt_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("fmt_valid_1cyc", fmt_valid, 1'b1);
        chk("fmt_inv_se", fmt_data, 32'hFFFF_0000);
        drive(1'b0, 14'h0, 14'h0);
        chk("fmt_valid_drop", fmt_valid, 1'b0);
        chk("fmt_hold", fmt_data, 32'hFFFF_0000);
        dfmt_type = 1'b0;
        drive(1'b1, 14'h2000, 14'h0123);
        chk("fmt_se_only", fmt_data, 32'h0123_E000);
        dfmt_enable = 1'b0;
        drive(1'b1, 14'h2000, 14'h1FFF);
        chk("fmt_disabled", fmt_data, 32'h1FFF_2000);

        // Ramp lock, back-to-back beats
        pn_seq_sel = 4'd3;
        drive(1'b0, 14'h0, 14'h0);
        rv = 0;
        repeat (4) ramp_beat();
        chk("ramp_oos_before", pn_oos, 1'b1);
        ramp_beat();
        chk("ramp_locked", pn_oos, 1'b0);
        chk("ramp_err0", err_cnt, 4'd0);

        // Ramp lock with gaps
        pn_seq_sel = 4'd0;
        drive(1'b0, 14'h0, 14'h0);
        chk("sel_off_oos", pn_oos, 1'b1);
        pn_seq_sel = 4'd3;
        drive(1'b0, 14'h0, 14'h0);
        rv = 100;
        repeat (4) begin
            ramp_beat();
            drive(1'b0, 14'h0, 14'h0);
            drive(1'b0, 14'h0, 14'h0);
        end
        chk("gap_oos_before", pn_oos, 1'b1);
        ramp_beat();
        chk("gap_locked", pn_oos, 1'b0);

        // Single error injection
        drive(1'b1, R'(rv), R'(rv + 77));
        chk("inj_pn_err", pn_err, 1'b1);
        chk("inj_err_cnt", err_cnt, 4'd1);
        chk("inj_still_locked", pn_oos, 1'b0);
        rv = rv + 78;
        ramp_beat();
        chk("inj_pn_err_done", pn_err, 1'b0);
        ramp_beat();
        chk("inj_err_cnt_stable", err_cnt, 4'd1);

        // Loss of lock and re-lock
        err_cnt_clr = 1'b1;
        drive(1'b0, 14'h0, 14'h0);
        err_cnt_clr = 1'b0;
        chk("clr_err_cnt", err_cnt, 4'd0);
        chk("clr_keeps_lock", pn_oos, 1'b0);
        repeat (3) bad_beat();
        chk("lol_still_locked", pn_oos, 1'b0);
        bad_beat();
        chk("lol_err_cnt", err_cnt, 4'd4);
        chk("lol_oos", pn_oos, 1'b1);
        repeat (3) ramp_beat();
        chk("relock_pending", pn_oos, 1'b1);
        ramp_beat();
        chk("relock", pn_oos, 1'b0);

        // PN9
        pn_seq_sel = 4'd1;
        drive(1'b0, 14'h0, 14'h0);
        repeat (4) pn_beat(1'b0, 1'b0);
        chk("pn9_oos_before", pn_oos, 1'b1);
        pn_beat(1'b0, 1'b0);
        chk("pn9_locked", pn_oos, 1'b0);
        pn_beat(1'b0, 1'b1);
        chk("pn9_flip_err", pn_err, 1'b1);
        chk("pn9_flip_cnt", err_cnt, 4'd5);
        pn_beat(1'b0, 1'b0);
        chk("pn9_after_flip", pn_err, 1'b0);
        chk("pn9_cnt_stable", err_cnt, 4'd5);

        // Switch to PN23 while locked
        pn_seq_sel = 4'd2;
        pn_beat(1'b1, 1'b0);
        chk("sel_switch_oos", pn_oos, 1'b1);
        repeat (3) pn_beat(1'b1, 1'b0);
        chk("pn23_oos_before", pn_oos, 1'b1);
        pn_beat(1'b1, 1'b0);
        chk("pn23_locked", pn_oos, 1'b0);
        pn_beat(1'b1, 1'b1);
        chk("pn23_flip_err", pn_err, 1'b1);
        chk("pn23_flip_cnt", err_cnt, 4'd6);
        pn_beat(1'b1, 1'b0);
        chk("pn23_after_flip", pn_err, 1'b0);

        // Saturation, clear, clear-vs-error, async reset
        pn_seq_sel = 4'd3;
        drive(1'b0, 14'h0, 14'h0);
        ramp_beat();
        repeat (5) begin
            repeat (4) ramp_beat();
            repeat (4) bad_beat();
        end
        chk("sat_err_cnt", err_cnt, 4'd15);
        err_cnt_clr = 1'b1;
        drive(1'b0, 14'h0, 14'h0);
        err_cnt_clr = 1'b0;
        chk("sat_clear", err_cnt, 4'd0);
        repeat (4) ramp_beat();
        chk("sat_relock", pn_oos, 1'b0);
        err_cnt_clr = 1'b1;
        bad_beat();
        err_cnt_clr = 1'b0;
        chk("clr_vs_err_pulse", pn_err, 1'b1);
        chk("clr_vs_err_cnt", err_cnt, 4'd0);
        ramp_beat();
        bad_beat();
        chk("pre_rst_cnt", err_cnt, 4'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fmt_valid", fmt_valid, 1'b0);
        chk("arst_fmt_data", fmt_data, 32'h0);
        chk("arst_pn_oos", pn_oos, 1'b1);
        chk("arst_pn_err", pn_err, 1'b0);
        chk("arst_err_cnt", err_cnt, 4'd0);
        raw_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) ramp_beat();
        chk("post_rst_oos", pn_oos, 1'b1);
        ramp_beat();
        chk("post_rst_locked", pn_oos, 1'b0);
        drive(1'b0, 14'h0, 14'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
